// File: rtl/reg_list_sequencer.sv
// reg_list_sequencer
//   Walks a 16-bit register list (lowest set bit first) for ARM LDM/STM
//   block transfers. Issues one word access per register over a valid/ready
//   memory handshake, writes loaded words into the register file, feeds the
//   register file read port for stores, and reports the final base value for
//   base-register writeback.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_start               begin a transfer (only honoured while idle)
//   i_load/i_up/i_before  LDM vs STM, increment vs decrement, pre vs post index
//   i_reg_list            bit i set = transfer register i
//   i_base_addr           base register value
//   i_mem_ready           memory accepts/completes the current access
//   i_mem_rdata           load data, valid with i_mem_ready
//   i_rf_data_a           register file read port A data
//   o_address_a           read port A address (current register)
//   o_rf_we/o_rf_wr_addr/o_rf_wr_data   register file write port
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata   memory access
//   o_busy, o_done        activity flag and one-cycle completion pulse
//   o_wb_addr, o_count    final base value and number of listed registers
module reg_list_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_load,
  input  logic        i_up,
  input  logic        i_before,
  input  logic [15:0] i_reg_list,
  input  logic [31:0] i_base_addr,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  input  logic [31:0] i_rf_data_a,
  output logic [3:0]  o_address_a,
  output logic [3:0]  o_rf_wr_addr,
  output logic [31:0] o_rf_wr_data,
  output logic        o_rf_we,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_wb_addr,
  output logic [4:0]  o_count
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_load;
  logic [15:0] r_pending;
  logic [31:0] r_addr;
  logic [31:0] r_wb_addr;
  logic [4:0]  r_count;
  logic [3:0]  r_wr_addr;
  logic [31:0] r_wr_data;

  logic [4:0]  w_popcount;
  logic [31:0] w_span;
  logic [31:0] w_first_addr;
  logic [31:0] w_wb_next;
  logic [3:0]  w_cur_idx;
  logic [15:0] w_pending_cleared;

  // Number of registers in the incoming list.
  always_comb begin
    w_popcount = '0;
    for (int i = 0; i < 16; i++) begin
      w_popcount = w_popcount + 5'(i_reg_list[i]);
    end
  end

  assign w_span = {25'd0, w_popcount, 2'b00};

  // The lowest register always lands on the lowest address, so decrementing
  // modes start at the bottom of the block and still walk upwards.
  always_comb begin
    case ({i_up, i_before})
      2'b10:   w_first_addr = i_base_addr;
      2'b11:   w_first_addr = i_base_addr + 32'd4;
      2'b00:   w_first_addr = i_base_addr - w_span + 32'd4;
      default: w_first_addr = i_base_addr - w_span;
    endcase
  end

  assign w_wb_next = i_up ? (i_base_addr + w_span) : (i_base_addr - w_span);

  // Lowest set bit of the pending list; scanning downwards lets the lowest
  // index win.
  always_comb begin
    w_cur_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_cur_idx = 4'(i);
      end
    end
  end

  // x & (x-1) drops exactly the lowest set bit, i.e. the current register.
  assign w_pending_cleared = r_pending & (r_pending - 16'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = (i_reg_list != 16'd0) ? S_XFER : S_DONE;
        end
      end
      S_XFER: begin
        if (i_mem_ready) begin
          if (r_load) begin
            w_state_next = S_WB;
          end else begin
            w_state_next = (w_pending_cleared != 16'd0) ? S_XFER : S_DONE;
          end
        end
      end
      S_WB:    w_state_next = (r_pending != 16'd0) ? S_XFER : S_DONE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Transfer context: latched on an accepted start, advanced on each
  // memory handshake. Load data is captured for the following WB cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_load    <= 1'b0;
      r_pending <= '0;
      r_addr    <= '0;
      r_wb_addr <= '0;
      r_count   <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_load    <= i_load;
            r_pending <= i_reg_list;
            r_count   <= w_popcount;
            r_addr    <= w_first_addr;
            r_wb_addr <= w_wb_next;
          end
        end
        S_XFER: begin
          if (i_mem_ready) begin
            r_pending <= w_pending_cleared;
            r_addr    <= r_addr + 32'd4;
            if (r_load) begin
              r_wr_addr <= w_cur_idx;
              r_wr_data <= i_mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes decode from the state register only, so they never glitch with
  // i_start. Store data is the only combinational path through the block.
  always_comb begin
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_rf_we     = 1'b0;
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_DONE);
    if (r_state == S_XFER) begin
      o_mem_req  = 1'b1;
      o_mem_we   = ~r_load;
      o_mem_addr = r_addr;
      if (!r_load) begin
        o_mem_wdata = i_rf_data_a;
      end
    end
    if (r_state == S_WB) begin
      o_rf_we = 1'b1;
    end
  end

  assign o_address_a  = w_cur_idx;
  assign o_rf_wr_addr = r_wr_addr;
  assign o_rf_wr_data = r_wr_data;
  assign o_wb_addr    = r_wb_addr;
  assign o_count      = r_count;

endmodule
